// File: rtl/codec_slot_ctrl.sv
// codec_slot_ctrl: sequences one compress and one decompress engine over a set
// of frame slots. It tracks which slots hold a valid compressed frame, rejects
// illegal requests, and drives registered start pulses and sticky finish flags.
// Optional build macro CODEC_TIMEOUT_EN adds a per-engine RUN watchdog.
// Without that macro the engines wait indefinitely and timeout_o is tied low.
module codec_slot_ctrl #(
    parameter int unsigned NUM_SLOTS   = 2,
    parameter int unsigned SLOT_W      = 1,
    parameter int unsigned TIMEOUT_W   = 16,
    parameter int unsigned TIMEOUT_CYC = 65535
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 cmp_req,
    input  logic [SLOT_W-1:0]    cmp_slot,
    output logic                 cmp_start,
    output logic [SLOT_W-1:0]    cmp_slot_o,
    output logic                 cmp_busy,
    input  logic                 cmp_done,
    output logic                 cmp_finish_o,
    input  logic                 dec_req,
    input  logic [SLOT_W-1:0]    dec_slot,
    output logic                 dec_start,
    output logic [SLOT_W-1:0]    dec_slot_o,
    output logic                 dec_busy,
    input  logic                 dec_done,
    output logic                 dec_finish_o,
    output logic [NUM_SLOTS-1:0] slot_valid,
    output logic                 err_o,
    output logic                 timeout_o
);

    localparam int unsigned SLOT_SPAN = 1 << SLOT_W;
    localparam int unsigned SLOT_WP   = SLOT_W + 1;
    localparam logic [SLOT_WP-1:0] NUM_SLOTS_W = SLOT_WP'(NUM_SLOTS);

    // Elaboration-time parameter sanity checks
    if (NUM_SLOTS > SLOT_SPAN) begin : g_bad_slot_w
        $error("codec_slot_ctrl: SLOT_W too narrow for NUM_SLOTS");
    end
    if (64'(TIMEOUT_CYC) >= (64'd1 << TIMEOUT_W)) begin : g_bad_timeout
        $error("codec_slot_ctrl: TIMEOUT_CYC does not fit in TIMEOUT_W bits");
    end

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_RUN   = 2'd2
    } state_e;

    state_e                cmp_state_q, cmp_state_d;
    state_e                dec_state_q, dec_state_d;
    logic                  cmp_start_q, cmp_start_d;
    logic                  dec_start_q, dec_start_d;
    logic [SLOT_W-1:0]     cmp_slot_q, cmp_slot_d;
    logic [SLOT_W-1:0]     dec_slot_q, dec_slot_d;
    logic                  cmp_busy_q, cmp_busy_d;
    logic                  dec_busy_q, dec_busy_d;
    logic                  cmp_fin_q, cmp_fin_d;
    logic                  dec_fin_q, dec_fin_d;
    logic [NUM_SLOTS-1:0]  slot_valid_q, slot_valid_d;
    logic                  err_q, err_d;

    logic [SLOT_SPAN-1:0]  valid_ext;
    logic                  cmp_ok, dec_ok;
    logic                  cmp_done_acc, dec_done_acc;
    logic                  cmp_end, dec_end;

`ifdef CODEC_TIMEOUT_EN
    logic [TIMEOUT_W-1:0]  cmp_wd_q, cmp_wd_d;
    logic [TIMEOUT_W-1:0]  dec_wd_q, dec_wd_d;
    logic                  tmo_q, tmo_d;
    logic                  cmp_tmo, dec_tmo;
`endif

    // Request arbitration: decompress is evaluated first so it wins a same-slot clash
    always_comb begin
        valid_ext = SLOT_SPAN'(slot_valid_q);

        dec_ok = dec_req
              && (dec_state_q == S_IDLE)
              && ({1'b0, dec_slot} < NUM_SLOTS_W)
              && valid_ext[dec_slot]
              && !(cmp_busy_q && (cmp_slot_q == dec_slot));

        cmp_ok = cmp_req
              && (cmp_state_q == S_IDLE)
              && ({1'b0, cmp_slot} < NUM_SLOTS_W)
              && !(dec_busy_q && (dec_slot_q == cmp_slot))
              && !(dec_ok && (dec_slot == cmp_slot));

        cmp_done_acc = (cmp_state_q == S_RUN) && cmp_done;
        dec_done_acc = (dec_state_q == S_RUN) && dec_done;
    end

`ifdef CODEC_TIMEOUT_EN
    // Saturating watchdogs count RUN cycles and abort an engine at TIMEOUT_CYC
    always_comb begin
        cmp_wd_d = '0;
        dec_wd_d = '0;
        if (cmp_state_q == S_RUN) begin
            cmp_wd_d = (cmp_wd_q == '1) ? cmp_wd_q : cmp_wd_q + TIMEOUT_W'(1);
        end
        if (dec_state_q == S_RUN) begin
            dec_wd_d = (dec_wd_q == '1) ? dec_wd_q : dec_wd_q + TIMEOUT_W'(1);
        end
        cmp_tmo = (cmp_state_q == S_RUN) && !cmp_done
               && (cmp_wd_d == TIMEOUT_W'(TIMEOUT_CYC));
        dec_tmo = (dec_state_q == S_RUN) && !dec_done
               && (dec_wd_d == TIMEOUT_W'(TIMEOUT_CYC));
        tmo_d   = cmp_tmo || dec_tmo;
        cmp_end = cmp_done_acc || cmp_tmo;
        dec_end = dec_done_acc || dec_tmo;
    end
`else
    // No watchdog: an engine leaves RUN only on its done pulse
    always_comb begin
        cmp_end = cmp_done_acc;
        dec_end = dec_done_acc;
    end
`endif

    // Next-state and registered-output computation for both engines
    always_comb begin
        cmp_state_d  = cmp_state_q;
        dec_state_d  = dec_state_q;
        cmp_start_d  = 1'b0;
        dec_start_d  = 1'b0;
        cmp_slot_d   = cmp_slot_q;
        dec_slot_d   = dec_slot_q;
        cmp_fin_d    = cmp_fin_q;
        dec_fin_d    = dec_fin_q;
        slot_valid_d = slot_valid_q;
        err_d        = (cmp_req && !cmp_ok) || (dec_req && !dec_ok);

        unique case (cmp_state_q)
            S_IDLE:  if (cmp_ok) cmp_state_d = S_START;
            S_START: cmp_state_d = S_RUN;
            S_RUN:   if (cmp_end) cmp_state_d = S_IDLE;
            default: cmp_state_d = S_IDLE;
        endcase

        unique case (dec_state_q)
            S_IDLE:  if (dec_ok) dec_state_d = S_START;
            S_START: dec_state_d = S_RUN;
            S_RUN:   if (dec_end) dec_state_d = S_IDLE;
            default: dec_state_d = S_IDLE;
        endcase

        if (cmp_ok) begin
            cmp_start_d = 1'b1;
            cmp_slot_d  = cmp_slot;
        end
        if (dec_ok) begin
            dec_start_d = 1'b1;
            dec_slot_d  = dec_slot;
        end

        // A slot being overwritten is invalid until its compress completes
        for (int i = 0; i < int'(NUM_SLOTS); i++) begin
            if (cmp_ok && (cmp_slot == SLOT_W'(i))) begin
                slot_valid_d[i] = 1'b0;
            end
            if (cmp_done_acc && (cmp_slot_q == SLOT_W'(i))) begin
                slot_valid_d[i] = 1'b1;
            end
        end

        if (cmp_ok) begin
            cmp_fin_d = 1'b0;
        end else if (cmp_done_acc) begin
            cmp_fin_d = 1'b1;
        end else if (dec_ok) begin
            cmp_fin_d = 1'b0;
        end

        if (dec_ok) begin
            dec_fin_d = 1'b0;
        end else if (dec_done_acc) begin
            dec_fin_d = 1'b1;
        end

        cmp_busy_d = (cmp_state_d != S_IDLE);
        dec_busy_d = (dec_state_d != S_IDLE);
    end

    // State and output registers
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cmp_state_q  <= S_IDLE;
            dec_state_q  <= S_IDLE;
            cmp_start_q  <= 1'b0;
            dec_start_q  <= 1'b0;
            cmp_slot_q   <= '0;
            dec_slot_q   <= '0;
            cmp_busy_q   <= 1'b0;
            dec_busy_q   <= 1'b0;
            cmp_fin_q    <= 1'b0;
            dec_fin_q    <= 1'b0;
            slot_valid_q <= '0;
            err_q        <= 1'b0;
        end else begin
            cmp_state_q  <= cmp_state_d;
            dec_state_q  <= dec_state_d;
            cmp_start_q  <= cmp_start_d;
            dec_start_q  <= dec_start_d;
            cmp_slot_q   <= cmp_slot_d;
            dec_slot_q   <= dec_slot_d;
            cmp_busy_q   <= cmp_busy_d;
            dec_busy_q   <= dec_busy_d;
            cmp_fin_q    <= cmp_fin_d;
            dec_fin_q    <= dec_fin_d;
            slot_valid_q <= slot_valid_d;
            err_q        <= err_d;
        end
    end

`ifdef CODEC_TIMEOUT_EN
    // Watchdog and timeout pulse registers
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cmp_wd_q <= '0;
            dec_wd_q <= '0;
            tmo_q    <= 1'b0;
        end else begin
            cmp_wd_q <= cmp_wd_d;
            dec_wd_q <= dec_wd_d;
            tmo_q    <= tmo_d;
        end
    end

    assign timeout_o = tmo_q;
`else
    assign timeout_o = 1'b0;
`endif

    assign cmp_start    = cmp_start_q;
    assign dec_start    = dec_start_q;
    assign cmp_slot_o   = cmp_slot_q;
    assign dec_slot_o   = dec_slot_q;
    assign cmp_busy     = cmp_busy_q;
    assign dec_busy     = dec_busy_q;
    assign cmp_finish_o = cmp_fin_q;
    assign dec_finish_o = dec_fin_q;
    assign slot_valid   = slot_valid_q;
    assign err_o        = err_q;

endmodule

// File: tb/tb_codec_slot_ctrl.sv
// Directed bench for codec_slot_ctrl with three slots (SLOT_W=2) and a short
// watchdog; the timeout scenario follows whether CODEC_TIMEOUT_EN is defined.
module tb_codec_slot_ctrl;

    localparam int unsigned NS   = 3;
    localparam int unsigned SW   = 2;
    localparam int unsigned TW   = 16;
    localparam int unsigned TCYC = 20;

    logic          clock;
    logic          reset_n;
    logic          cmp_req, dec_req, cmp_done, dec_done;
    logic [SW-1:0] cmp_slot, dec_slot;
    logic          cmp_start, dec_start, cmp_busy, dec_busy;
    logic [SW-1:0] cmp_slot_o, dec_slot_o;
    logic          cmp_finish_o, dec_finish_o, err_o, timeout_o;
    logic [NS-1:0] slot_valid;

    int n_tests = 0;
    int n_fail  = 0;

    codec_slot_ctrl #(
        .NUM_SLOTS  (NS),
        .SLOT_W     (SW),
        .TIMEOUT_W  (TW),
        .TIMEOUT_CYC(TCYC)
    ) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .cmp_req     (cmp_req),
        .cmp_slot    (cmp_slot),
        .cmp_start   (cmp_start),
        .cmp_slot_o  (cmp_slot_o),
        .cmp_busy    (cmp_busy),
        .cmp_done    (cmp_done),
        .cmp_finish_o(cmp_finish_o),
        .dec_req     (dec_req),
        .dec_slot    (dec_slot),
        .dec_start   (dec_start),
        .dec_slot_o  (dec_slot_o),
        .dec_busy    (dec_busy),
        .dec_done    (dec_done),
        .dec_finish_o(dec_finish_o),
        .slot_valid  (slot_valid),
        .err_o       (err_o),
        .timeout_o   (timeout_o)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_cmp_start"}, 32'(cmp_start), 32'd0);
        check({tag, "_dec_start"}, 32'(dec_start), 32'd0);
        check({tag, "_cmp_busy"},  32'(cmp_busy),  32'd0);
        check({tag, "_dec_busy"},  32'(dec_busy),  32'd0);
        check({tag, "_cmp_fin"},   32'(cmp_finish_o), 32'd0);
        check({tag, "_dec_fin"},   32'(dec_finish_o), 32'd0);
        check({tag, "_cmp_slot"},  32'(cmp_slot_o), 32'd0);
        check({tag, "_dec_slot"},  32'(dec_slot_o), 32'd0);
        check({tag, "_valid"},     32'(slot_valid), 32'd0);
        check({tag, "_err"},       32'(err_o),     32'd0);
        check({tag, "_tmo"},       32'(timeout_o), 32'd0);
    endtask

    initial begin
        reset_n  = 1'b0;
        cmp_req  = 1'b0; dec_req  = 1'b0;
        cmp_done = 1'b0; dec_done = 1'b0;
        cmp_slot = '0;   dec_slot = '0;
        repeat (3) tick();
        check_idle_outputs("reset");
        reset_n = 1'b1;
        tick();

        // 1: compress slot 1, done four cycles after start
        cmp_req = 1'b1; cmp_slot = 2'd1;
        tick();                                     // n+1
        cmp_req = 1'b0;
        check("t1_start", 32'(cmp_start), 32'd1);
        check("t1_busy",  32'(cmp_busy),  32'd1);
        check("t1_slot",  32'(cmp_slot_o), 32'd1);
        tick();                                     // n+2
        check("t1_start_pulse", 32'(cmp_start), 32'd0);
        check("t1_busy_run",    32'(cmp_busy),  32'd1);
        tick(); tick();                             // n+4
        check("t1_valid_pending", 32'(slot_valid), 32'd0);
        tick();                                     // n+5
        cmp_done = 1'b1;
        tick();                                     // n+6
        cmp_done = 1'b0;
        check("t1_valid", 32'(slot_valid), 32'b010);
        check("t1_fin",   32'(cmp_finish_o), 32'd1);
        check("t1_idle",  32'(cmp_busy), 32'd0);

        // done outside RUN is ignored
        dec_done = 1'b1;
        tick();
        dec_done = 1'b0;
        check("t1_stray_done", 32'(dec_finish_o), 32'd0);

        // 2: decompress of an empty slot is rejected, of a full slot accepted
        dec_req = 1'b1; dec_slot = 2'd0;
        tick();
        dec_req = 1'b0;
        check("t2_err",      32'(err_o),     32'd1);
        check("t2_no_start", 32'(dec_start), 32'd0);
        check("t2_no_busy",  32'(dec_busy),  32'd0);
        tick();
        check("t2_err_pulse", 32'(err_o), 32'd0);
        dec_req = 1'b1; dec_slot = 2'd1;
        tick();
        dec_req = 1'b0;
        check("t2_start", 32'(dec_start), 32'd1);
        check("t2_slot",  32'(dec_slot_o), 32'd1);
        check("t2_err_none", 32'(err_o), 32'd0);
        tick();                                     // RUN
        dec_done = 1'b1;
        tick();
        dec_done = 1'b0;
        check("t2_dec_fin", 32'(dec_finish_o), 32'd1);
        check("t2_cmp_fin", 32'(cmp_finish_o), 32'd0);
        check("t2_idle",    32'(dec_busy), 32'd0);
        check("t2_valid",   32'(slot_valid), 32'b010);

        // 3: fill slot 0, then same-slot clash and different-slot parallel start
        cmp_req = 1'b1; cmp_slot = 2'd0;
        tick();
        cmp_req = 1'b0;
        tick();
        cmp_done = 1'b1;
        tick();
        cmp_done = 1'b0;
        check("t3_valid_full", 32'(slot_valid), 32'b011);
        cmp_req = 1'b1; cmp_slot = 2'd0;
        dec_req = 1'b1; dec_slot = 2'd0;
        tick();
        cmp_req = 1'b0; dec_req = 1'b0;
        check("t3_clash_dec_start", 32'(dec_start), 32'd1);
        check("t3_clash_cmp_start", 32'(cmp_start), 32'd0);
        check("t3_clash_err",       32'(err_o),     32'd1);
        check("t3_clash_valid",     32'(slot_valid), 32'b011);
        tick();
        dec_done = 1'b1;
        tick();
        dec_done = 1'b0;
        check("t3_dec_idle", 32'(dec_busy), 32'd0);
        cmp_req = 1'b1; cmp_slot = 2'd0;
        dec_req = 1'b1; dec_slot = 2'd1;
        tick();
        cmp_req = 1'b0; dec_req = 1'b0;
        check("t3_par_cmp_start", 32'(cmp_start), 32'd1);
        check("t3_par_dec_start", 32'(dec_start), 32'd1);
        check("t3_par_err",       32'(err_o),     32'd0);
        check("t3_par_valid",     32'(slot_valid), 32'b010);
        tick();
        cmp_done = 1'b1; dec_done = 1'b1;
        tick();
        cmp_done = 1'b0; dec_done = 1'b0;
        check("t3_par_valid_end", 32'(slot_valid), 32'b011);
        check("t3_par_cmp_fin",   32'(cmp_finish_o), 32'd1);
        check("t3_par_dec_fin",   32'(dec_finish_o), 32'd1);

        // 4: out-of-range slot and request while busy are rejected
        cmp_req = 1'b1; cmp_slot = 2'd3;
        tick();
        cmp_req = 1'b0;
        check("t4_range_err",   32'(err_o),     32'd1);
        check("t4_range_start", 32'(cmp_start), 32'd0);
        check("t4_range_busy",  32'(cmp_busy),  32'd0);
        cmp_req = 1'b1; cmp_slot = 2'd2;
        tick();
        check("t4_start2", 32'(cmp_start), 32'd1);
        check("t4_slot2",  32'(cmp_slot_o), 32'd2);
        cmp_slot = 2'd0;
        tick();
        cmp_req = 1'b0;
        check("t4_busy_err",  32'(err_o), 32'd1);
        check("t4_busy_slot", 32'(cmp_slot_o), 32'd2);
        check("t4_busy_valid", 32'(slot_valid), 32'b011);
        dec_req = 1'b1; dec_slot = 2'd1;
        tick();
        dec_req = 1'b0;
        check("t4_dec_start", 32'(dec_start), 32'd1);
        tick();                                     // both engines in RUN

        // 6: asynchronous reset mid-RUN
        #2 reset_n = 1'b0;
        #1;
        check_idle_outputs("t6_async");
        tick();
        reset_n = 1'b1;
        tick();
        dec_req = 1'b1; dec_slot = 2'd1;
        tick();
        dec_req = 1'b0;
        check("t6_dec_err",   32'(err_o),     32'd1);
        check("t6_dec_start", 32'(dec_start), 32'd0);

        // 5: compress with no done pulse
        cmp_req = 1'b1; cmp_slot = 2'd0;
        tick();
        cmp_req = 1'b0;
        check("t5_start", 32'(cmp_start), 32'd1);
`ifdef CODEC_TIMEOUT_EN
        begin
            int waited;
            waited = 0;
            while (timeout_o !== 1'b1 && waited < 4 * TCYC) begin
                tick();
                waited++;
            end
            // start cycle then TCYC RUN cycles, timeout visible on the next one
            check("t5_tmo_cycle", 32'(waited), 32'(TCYC + 1));
            check("t5_tmo",       32'(timeout_o), 32'd1);
            check("t5_tmo_busy",  32'(cmp_busy),  32'd0);
            check("t5_tmo_valid", 32'(slot_valid), 32'd0);
            check("t5_tmo_fin",   32'(cmp_finish_o), 32'd0);
            tick();
            check("t5_tmo_pulse", 32'(timeout_o), 32'd0);
        end
`else
        repeat (1000) tick();
        check("t5_hold_busy",  32'(cmp_busy),  32'd1);
        check("t5_hold_tmo",   32'(timeout_o), 32'd0);
        check("t5_hold_valid", 32'(slot_valid), 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
